// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stage registers of the RV32IM core.
package pipe_pkg;

  // Stage occupancy state. The numeric value equals the number of held entries.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HOLD  = 2'd1,
    ST_SKIDF = 2'd2
  } pipe_state_e;

  // Control-field widths of the individual stage registers.
  localparam int IFID_CTRL_W  = 2;
  localparam int IDEX_CTRL_W  = 12;
  localparam int EXMEM_CTRL_W = 8;
  localparam int MEMWB_CTRL_W = 4;

  // Number of entries held in a given state.
  function automatic logic [1:0] state_count(input pipe_state_e st);
    case (st)
      ST_HOLD:  state_count = 2'd1;
      ST_SKIDF: state_count = 2'd2;
      default:  state_count = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_entry.sv
// One pipeline entry: valid flag, control field and payload register.
// Clearing drops valid and zeroes control but leaves the payload untouched,
// so a bubble never carries live control bits downstream.
module pipe_entry #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [DATA_W-1:0] data_q;

  // Entry register: reset beats clear, clear beats load.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      ctrl_q  <= ctrl_i;
      data_q  <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign ctrl_o  = ctrl_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline stage with valid/ready handshake, flush and an optional
// two-entry skid buffer. With the skid buffer, in_ready comes straight from the
// skid entry's valid flag, which breaks the combinational ready path.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int CTRL_W = EXMEM_CTRL_W,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        count
);

  pipe_state_e state_q, state_d;
  logic [1:0]  count_q;

  logic              main_valid, skid_valid;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_ctrl_in;
  logic [DATA_W-1:0] main_data, skid_data, main_data_in;

  logic accept, send;
  logic load_main, clr_main, load_skid, clr_skid, main_from_skid;

  // An instruction offered during flush is dropped even when in_ready is high.
  assign accept = in_valid & in_ready & ~flush;
  assign send   = main_valid & out_ready;

  // Next-state and entry control of the handshake FSM.
  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    clr_main       = 1'b0;
    load_skid      = 1'b0;
    clr_skid       = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      state_d  = ST_EMPTY;
      clr_main = 1'b1;
      clr_skid = 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            load_main = 1'b1;
            state_d   = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (accept && send) begin
            load_main = 1'b1;
          end else if (accept && !send && (SKID != 0)) begin
            load_skid = 1'b1;
            state_d   = ST_SKIDF;
          end else if (send) begin
            clr_main = 1'b1;
            state_d  = ST_EMPTY;
          end
        end
        ST_SKIDF: begin
          if (send) begin
            load_main      = 1'b1;
            main_from_skid = 1'b1;
            clr_skid       = 1'b1;
            state_d        = ST_HOLD;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // State register and occupancy count share the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      count_q <= 2'd0;
    end else begin
      state_q <= state_d;
      count_q <= state_count(state_d);
    end
  end

  assign main_ctrl_in = main_from_skid ? skid_ctrl : in_ctrl;
  assign main_data_in = main_from_skid ? skid_data : in_data;

  pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
    .clk     (clk),
    .reset   (reset),
    .load_i  (load_main),
    .clear_i (clr_main),
    .ctrl_i  (main_ctrl_in),
    .data_i  (main_data_in),
    .valid_o (main_valid),
    .ctrl_o  (main_ctrl),
    .data_o  (main_data)
  );

  generate
    if (SKID != 0) begin : g_skid
      pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
        .clk     (clk),
        .reset   (reset),
        .load_i  (load_skid),
        .clear_i (clr_skid),
        .ctrl_i  (in_ctrl),
        .data_i  (in_data),
        .valid_o (skid_valid),
        .ctrl_o  (skid_ctrl),
        .data_o  (skid_data)
      );
      // Skid entry occupied exactly in SKIDF, so this is a registered ready.
      assign in_ready = ~skid_valid;
    end else begin : g_noskid
      assign skid_valid = 1'b0;
      assign skid_ctrl  = '0;
      assign skid_data  = '0;
      assign in_ready   = ~main_valid | out_ready;
    end
  endgenerate

  assign out_valid = main_valid;
  assign out_ctrl  = main_ctrl;
  assign out_data  = main_data;
  assign count     = count_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: one instance with skid buffer, one without.
// A per-instance queue holds the entries the stage should be holding; a monitor
// compares the DUT against it every cycle while directed and random stimulus run.
module tb_pipe_stage_skid;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        f1, v1, r1, ir1, ov1;
  logic [7:0]  c1, oc1;
  logic [63:0] d1, od1;
  logic [1:0]  cnt1;

  logic        f0, v0, r0, ir0, ov0;
  logic [7:0]  c0, oc0;
  logic [63:0] d0, od0;
  logic [1:0]  cnt0;

  pipe_stage_skid #(.DATA_W(64), .CTRL_W(8), .SKID(1)) dut1 (
    .clk(clk), .reset(reset), .flush(f1), .in_valid(v1), .in_ready(ir1),
    .in_ctrl(c1), .in_data(d1), .out_valid(ov1), .out_ready(r1),
    .out_ctrl(oc1), .out_data(od1), .count(cnt1)
  );

  pipe_stage_skid #(.DATA_W(64), .CTRL_W(8), .SKID(0)) dut0 (
    .clk(clk), .reset(reset), .flush(f0), .in_valid(v0), .in_ready(ir0),
    .in_ctrl(c0), .in_data(d0), .out_valid(ov0), .out_ready(r0),
    .out_ctrl(oc0), .out_data(od0), .count(cnt0)
  );

  typedef struct {
    logic [7:0]  c;
    logic [63:0] d;
  } item_t;

  item_t q1[$];
  item_t q0[$];
  int    checks = 0;
  int    errors = 0;
  int    pops0  = 0;
  int    pops1  = 0;
  bit    verbose = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare one instance against its queue, then update the queue with this
  // cycle's transfers (pop on send, drop all on flush, push on accept).
  task automatic mon(input int k, input logic ov, input logic orr, input logic ir,
                     input logic iv, input logic fl, input logic [1:0] cnt,
                     input logic [7:0] oc, input logic [7:0] ic,
                     input logic [63:0] od, input logic [63:0] id);
    item_t it, hd;
    int    sz;
    logic  exp_ir;
    sz = (k == 1) ? q1.size() : q0.size();
    exp_ir = (k == 1) ? (sz < 2) : ((sz == 0) || orr);
    chk($sformatf("dut%0d count", k), 64'(cnt), 64'(sz));
    chk($sformatf("dut%0d out_valid", k), 64'(ov), 64'(sz != 0));
    chk($sformatf("dut%0d in_ready", k), 64'(ir), 64'(exp_ir));
    if (!ov) chk($sformatf("dut%0d bubble ctrl", k), 64'(oc), 64'd0);
    if (ov && sz != 0) begin
      hd = (k == 1) ? q1[0] : q0[0];
      chk($sformatf("dut%0d out_ctrl", k), 64'(oc), 64'(hd.c));
      chk($sformatf("dut%0d out_data", k), od, hd.d);
      if (orr) begin
        if (verbose) $display("dut%0d out ctrl=%h data=%h", k, oc, od);
        if (k == 1) begin void'(q1.pop_front()); pops1++; end
        else begin void'(q0.pop_front()); pops0++; end
      end
    end
    if (fl) begin
      if (k == 1) q1.delete(); else q0.delete();
    end else if (iv && ir) begin
      it.c = ic;
      it.d = id;
      if (k == 1) q1.push_back(it); else q0.push_back(it);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        q1.delete();
        q0.delete();
      end else begin
        mon(1, ov1, r1, ir1, v1, f1, cnt1, oc1, c1, od1, d1);
        mon(0, ov0, r0, ir0, v0, f0, cnt0, oc0, c0, od0, d0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv1(input logic v, input logic [7:0] c, input logic [63:0] d,
                      input logic f, input logic rr);
    v1 = v; c1 = c; d1 = d; f1 = f; r1 = rr;
  endtask

  initial begin
    reset = 1'b1;
    drv1(0, 8'h00, 64'h0, 0, 0);
    v0 = 0; c0 = 0; d0 = 0; f0 = 0; r0 = 0;

    // 1: reset for two cycles
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst out_valid", 64'(ov1), 64'd0);
    chk("rst out_ctrl", 64'(oc1), 64'd0);
    chk("rst out_data", od1, 64'd0);
    chk("rst count", 64'(cnt1), 64'd0);
    chk("rst in_ready", 64'(ir1), 64'd1);
    chk("rst0 out_valid", 64'(ov0), 64'd0);
    chk("rst0 in_ready", 64'(ir0), 64'd1);

    // 2: streaming with out_ready=1
    drv1(1, 8'h11, 64'd1, 0, 1); step();
    chk("stream d1", od1, 64'd1);
    chk("stream ready1", 64'(ir1), 64'd1);
    drv1(1, 8'h12, 64'd2, 0, 1); step();
    chk("stream d2", od1, 64'd2);
    chk("stream ready2", 64'(ir1), 64'd1);
    drv1(1, 8'h13, 64'd3, 0, 1); step();
    chk("stream d3", od1, 64'd3);
    drv1(0, 8'h00, 64'd0, 0, 1); step();
    chk("stream drained", 64'(ov1), 64'd0);

    // 3: stall fills the skid buffer, then drains in order
    drv1(1, 8'hA5, 64'hA, 0, 0); step();
    chk("stall count1", 64'(cnt1), 64'd1);
    drv1(1, 8'hB5, 64'hB, 0, 0); step();
    chk("stall count2", 64'(cnt1), 64'd2);
    chk("stall in_ready", 64'(ir1), 64'd0);
    chk("stall hold A", od1, 64'hA);
    drv1(0, 8'h00, 64'h0, 0, 0); step();
    chk("stall still A", od1, 64'hA);
    drv1(0, 8'h00, 64'h0, 0, 1); step();
    chk("drain B", od1, 64'hB);
    chk("drain count1", 64'(cnt1), 64'd1);
    step();
    chk("drain count0", 64'(cnt1), 64'd0);

    // 4: flush in SKIDF with C offered, then flush in HOLD with in_ready=1
    drv1(1, 8'hA6, 64'hA2, 0, 0); step();
    drv1(1, 8'hB6, 64'hB2, 0, 0); step();
    drv1(1, 8'hC6, 64'hC, 1, 0); step();
    chk("flush out_valid", 64'(ov1), 64'd0);
    chk("flush out_ctrl", 64'(oc1), 64'd0);
    chk("flush count", 64'(cnt1), 64'd0);
    chk("flush in_ready", 64'(ir1), 64'd1);
    drv1(1, 8'hD6, 64'hD, 0, 0); step();
    drv1(1, 8'hE6, 64'hE, 1, 0); step();
    chk("flush hold count", 64'(cnt1), 64'd0);
    drv1(0, 8'h00, 64'h0, 0, 1); step();
    chk("flush nothing out", 64'(ov1), 64'd0);

    // 5: reset beats flush and in_valid
    drv1(1, 8'hF6, 64'hF, 0, 0); step();
    reset = 1'b1;
    drv1(1, 8'h77, 64'h77, 1, 0); step();
    reset = 1'b0;
    drv1(0, 8'h00, 64'h0, 0, 0);
    chk("rst2 out_valid", 64'(ov1), 64'd0);
    chk("rst2 out_ctrl", 64'(oc1), 64'd0);
    chk("rst2 out_data", od1, 64'd0);
    chk("rst2 count", 64'(cnt1), 64'd0);
    chk("rst2 in_ready", 64'(ir1), 64'd1);

    // 6: SKID=0 combinational ready
    v0 = 1; c0 = 8'h07; d0 = 64'h77; r0 = 0; step();
    v0 = 0; #1;
    chk("noskid ready stall", 64'(ir0), 64'd0);
    r0 = 1; #1;
    chk("noskid ready go", 64'(ir0), 64'd1);
    step();

    // random phase on both instances, occasional flush on the skid instance
    verbose = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      v0 = 1'($urandom_range(0, 1));
      r0 = 1'($urandom_range(0, 1));
      c0 = 8'($urandom);
      d0 = {32'(n), 32'($urandom)};
      v1 = 1'($urandom_range(0, 1));
      r1 = 1'($urandom_range(0, 1));
      f1 = ($urandom_range(0, 31) == 0);
      c1 = 8'($urandom);
      d1 = {32'(n), 32'($urandom)};
      step();
    end
    verbose = 1'b1;
    v0 = 0; r0 = 1; drv1(0, 8'h00, 64'h0, 0, 1);
    repeat (4) step();
    chk("end count1", 64'(cnt1), 64'd0);
    chk("end count0", 64'(cnt0), 64'd0);
    chk("noskid activity", 64'(pops0 > 100), 64'd1);
    chk("skid activity", 64'(pops1 > 100), 64'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
